dispense_sensor_monitor: RTL and testbench

// Receive side of the dispense interface. Takes per-slot dispense requests
// (morning/afternoon/evening pulses), drives the dispenser motor GPIO, and

---
 rtl/dispense_sensor_monitor.sv | 145 ++++++++++++++
 tb/tb_dispense_sensor_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dispense_sensor_monitor.sv
// dispense_sensor_monitor: drives the pill dispenser motor per slot request, confirms drops via a debounced beam sensor, retries and flags missed doses
module dispense_sensor_monitor #(
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int TIMEOUT_CYC  = 100_000_000,
  parameter int GAP_CYC      = 25_000_000,
  parameter int MAX_RETRY    = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [2:0] dispense_req,
  input  logic       sensor_n,
  input  logic       ack_n,
  output logic       motor_en,
  output logic       busy,
  output logic       done_pulse,
  output logic [1:0] slot_done,
  output logic       spurious,
  output logic       miss_alarm,
  output logic [2:0] miss_slot,
  output logic [7:0] dose_count
);
  localparam int TW = $clog2(TIMEOUT_CYC > GAP_CYC ? TIMEOUT_CYC : GAP_CYC);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  typedef enum logic [2:0] {IDLE, DRIVE, GAP, DONE, MISS} state_t;
  state_t        state_q, state_d;
  logic          sens_s1_q, sens_s2_q, ack_s1_q, ack_s2_q;
  logic          filt_q, filt_d, drop_q, drop_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [2:0]    pending_q, pending_d, pend, sel_oh;
  logic [1:0]    slot_q, slot_d, slot_done_q, slot_done_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          motor_q, motor_d, busy_q, busy_d, done_q, done_d;
  logic          spur_q, spur_d, alarm_q, alarm_d;
  logic [2:0]    miss_slot_q, miss_slot_d;
  logic [7:0]    dose_q, dose_d;

  // Filtered sensor flips only after the synced level disagrees for DEBOUNCE_CYC cycles; drop is its 1->0 edge
  always_comb begin
    deb_d  = (sens_s2_q != filt_q && deb_q != DW'(DEBOUNCE_CYC - 1)) ? deb_q + DW'(1) : '0;
    filt_d = (sens_s2_q != filt_q && deb_q == DW'(DEBOUNCE_CYC - 1)) ? sens_s2_q : filt_q;
    drop_d = filt_q & ~filt_d;
  end

  // Dispense sequencing, request bookkeeping and the next value of every registered output
  always_comb begin
    pend      = pending_q | dispense_req;
    sel_oh    = 3'b001 << slot_q;
    pending_d = (pending_q & ~((state_q == DONE || state_q == MISS) ? sel_oh : 3'b000)) | dispense_req;
    state_d   = state_q;
    slot_d    = slot_q;
    retry_d   = retry_q;
    timer_d   = timer_q;
    case (state_q)
      IDLE: if (pend != 3'b000) begin
        state_d = DRIVE;
        slot_d  = pend[0] ? 2'd0 : pend[1] ? 2'd1 : 2'd2;
        retry_d = '0;
        timer_d = '0;
      end
      DRIVE: begin
        timer_d = timer_q + TW'(1);
        if (drop_q) state_d = DONE;
        else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = (retry_q == RW'(MAX_RETRY)) ? MISS : GAP;
          timer_d = '0;
        end
      end
      GAP: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == TW'(GAP_CYC - 1)) begin
          state_d = DRIVE;
          retry_d = retry_q + RW'(1);
          timer_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    motor_d     = state_d == DRIVE;
    busy_d      = state_d != IDLE;
    done_d      = state_d == DONE;
    slot_done_d = (state_d == DONE) ? slot_d : slot_done_q;
    dose_d      = (state_d == DONE && dose_q != 8'hFF) ? dose_q + 8'd1 : dose_q;
    spur_d      = drop_q && (state_q == IDLE || state_q == GAP);
    alarm_d     = (alarm_q & ack_s2_q) | (state_q == MISS);
    miss_slot_d = (miss_slot_q & {3{ack_s2_q}}) | ((state_q == MISS) ? sel_oh : 3'b000);
  end

  // All state registers; reset parks the sensor path at "beam clear" and the ack path at "not pressed"
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      sens_s1_q   <= 1'b1;
      sens_s2_q   <= 1'b1;
      ack_s1_q    <= 1'b1;
      ack_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      deb_q       <= '0;
      drop_q      <= 1'b0;
      pending_q   <= '0;
      state_q     <= IDLE;
      slot_q      <= '0;
      retry_q     <= '0;
      timer_q     <= '0;
      motor_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      slot_done_q <= '0;
      spur_q      <= 1'b0;
      alarm_q     <= 1'b0;
      miss_slot_q <= '0;
      dose_q      <= '0;
    end else begin
      sens_s1_q   <= sensor_n;
      sens_s2_q   <= sens_s1_q;
      ack_s1_q    <= ack_n;
      ack_s2_q    <= ack_s1_q;
      filt_q      <= filt_d;
      deb_q       <= deb_d;
      drop_q      <= drop_d;
      pending_q   <= pending_d;
      state_q     <= state_d;
      slot_q      <= slot_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
      motor_q     <= motor_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      slot_done_q <= slot_done_d;
      spur_q      <= spur_d;
      alarm_q     <= alarm_d;
      miss_slot_q <= miss_slot_d;
      dose_q      <= dose_d;
    end
  end

  assign motor_en   = motor_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;
  assign slot_done  = slot_done_q;
  assign spurious   = spur_q;
  assign miss_alarm = alarm_q;
  assign miss_slot  = miss_slot_q;
  assign dose_count = dose_q;
endmodule

// File: tb/tb_dispense_sensor_monitor.sv
// tb_dispense_sensor_monitor: randomized scoreboard bench for dispense_sensor_monitor
module tb_dispense_sensor_monitor;
  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] dispense_req = 3'b000;
  logic       sensor_n = 1'b1;
  logic       ack_n = 1'b1;
  logic       motor_en, busy, done_pulse, spurious, miss_alarm;
  logic [1:0] slot_done;
  logic [2:0] miss_slot;
  logic [7:0] dose_count;

  dispense_sensor_monitor #(.DEBOUNCE_CYC(4), .TIMEOUT_CYC(50), .GAP_CYC(10), .MAX_RETRY(2)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .dispense_req(dispense_req), .sensor_n(sensor_n), .ack_n(ack_n),
    .motor_en(motor_en), .busy(busy), .done_pulse(done_pulse), .slot_done(slot_done), .spurious(spurious),
    .miss_alarm(miss_alarm), .miss_slot(miss_slot), .dose_count(dose_count));

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {int kind; int slot; int t; int mcnt; int dose;} ev_t;
  localparam int K_DONE = 0, K_MISS = 1, K_SPUR = 2;
  ev_t q[$];
  int checks = 0, errors = 0, exp_dose = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int kind, input int slot, input int t, input int mcnt);
    ev_t e;
    if (kind == K_DONE) exp_dose = (exp_dose < 255) ? exp_dose + 1 : 255;
    e = '{kind, slot, t, mcnt, exp_dose};
    q.push_back(e);
  endtask

  int mcnt = 0;
  logic [2:0] prev_ms = 3'b000;

  task automatic pop_cmp(input int kind, input int slot);
    ev_t e;
    if (q.size() == 0) begin
      chk("unexpected_event_kind", kind, -1);
      return;
    end
    e = q.pop_front();
    chk("event_kind", kind, e.kind);
    chk("event_slot", slot, e.slot);
    chk("event_cycle", cyc, e.t);
    if (kind != K_SPUR) begin
      chk("motor_on_cycles", mcnt, e.mcnt);
      mcnt = 0;
    end
    if (kind == K_DONE) chk("dose_count", dose_count, e.dose);
    if (kind == K_MISS) chk("miss_alarm_set", miss_alarm, 1);
  endtask

  // monitor: pops and compares whenever the DUT presents an event
  initial begin : mon
    forever begin
      @(negedge CLOCK_50);
      if (!reset) begin
        mcnt = 0;
        prev_ms = miss_slot;
      end else begin
        if (done_pulse) pop_cmp(K_DONE, int'(slot_done));
        for (int i = 0; i < 3; i++) if (miss_slot[i] && !prev_ms[i]) pop_cmp(K_MISS, i);
        if (spurious) pop_cmp(K_SPUR, 0);
        if (motor_en) mcnt++;
        prev_ms = miss_slot;
      end
    end
  end

  task automatic run_txn(input logic [2:0] req, input int l1, input int h1, input int l2, input int h2,
                         input int a1, input int a2, input int n);
    for (int r = 0; r < n; r++) begin
      dispense_req = (r == 0) ? req : 3'b000;
      sensor_n = !((r >= l1 && r < l1 + h1) || (r >= l2 && r < l2 + h2));
      ack_n = !(r == a1 || r == a2);
      @(posedge CLOCK_50);
      #1;
    end
    dispense_req = 3'b000;
    sensor_n = 1'b1;
    ack_n = 1'b1;
  endtask

  // reference model: attempt a drives on rel cycles 1+60a..50+60a; a drop is seen 6 cycles after the sensor falls
  task automatic single(input int slot, input int l, input int hold, input bit do_ack);
    int t0, d, last, miss;
    bit served;
    t0 = cyc;
    d = (hold >= 4) ? l + 6 : -1;
    served = 0;
    miss = 0;
    last = l + hold + 8;
    for (int a = 0; a < 3; a++)
      if (d >= 1 + 60 * a && d <= 50 + 60 * a) begin
        push(K_DONE, slot, t0 + d + 1, d - 10 * a);
        served = 1;
        last = (d + 1 > last) ? d + 1 : last;
      end
    if (!served) begin
      if (d > 0) push(K_SPUR, 0, t0 + d + 1, 0);
      push(K_MISS, slot, t0 + 172, 150);
      miss = 1;
      last = 172 + 8;
    end
    run_txn(3'b001 << slot, l, hold, -100, 0, (miss && do_ack) ? 174 : -1, -1, last + 4);
    chk("busy_idle_after_txn", busy, 0);
    if (miss && do_ack) chk("alarm_cleared_by_ack", miss_alarm, 0);
    chk("scoreboard_drained", q.size(), 0);
    q.delete();
  endtask

  initial begin : stim
    int t0, slot, mode, a, off, l, hold;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_motor_en", motor_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_pulse", done_pulse, 0);
    chk("rst_slot_done", slot_done, 0);
    chk("rst_spurious", spurious, 0);
    chk("rst_miss_alarm", miss_alarm, 0);
    chk("rst_miss_slot", miss_slot, 0);
    chk("rst_dose_count", dose_count, 0);
    reset = 1'b1;
    repeat (8) @(posedge CLOCK_50);
    #1;
    single(0, 20, 10, 1);
    single(0, -100, 0, 1);
    single(1, 20, 3, 1);
    t0 = cyc;
    push(K_DONE, 1, t0 + 27, 26);
    push(K_DONE, 2, t0 + 67, 38);
    run_txn(3'b110, 20, 10, 60, 6, -1, -1, 80);
    chk("busy_idle_after_pair", busy, 0);
    chk("pair_drained", q.size(), 0);
    q.delete();
    for (int k = 0; k < 30; k++) begin
      slot = $urandom_range(0, 2);
      mode = $urandom_range(0, 5);
      hold = $urandom_range(4, 8);
      if (mode <= 2) begin
        a = mode;
        case ($urandom_range(0, 3))
          0: off = 49;
          1: off = (a == 0) ? 6 : 0;
          default: off = $urandom_range((a == 0) ? 6 : 0, 49);
        endcase
        single(slot, 1 + 60 * a + off - 6, hold, 1);
      end else if (mode == 3) single(slot, -100, 0, 1);
      else if (mode == 4) single(slot, 51 + 60 * $urandom_range(0, 1) + $urandom_range(0, 9) - 6, hold, 1);
      else single(slot, $urandom_range(5, 150), $urandom_range(1, 3), 1);
    end
    t0 = cyc;
    push(K_MISS, 2, t0 + 172, 150);
    run_txn(3'b100, -100, 0, -100, 0, 169, -1, 174);
    chk("ack_in_miss_cycle_alarm_holds", miss_alarm, 1);
    chk("ack_in_miss_cycle_slot_holds", miss_slot, 3'b100);
    run_txn(3'b000, -100, 0, -100, 0, 2, -1, 8);
    chk("later_ack_clears_alarm", miss_alarm, 0);
    chk("later_ack_clears_slot", miss_slot, 0);
    chk("ack_drained", q.size(), 0);
    q.delete();
    single(1, -100, 0, 0);
    chk("alarm_held_without_ack", miss_alarm, 1);
    chk("slot_held_without_ack", miss_slot, 3'b010);
    run_txn(3'b001, -100, 0, -100, 0, -1, -1, 30);
    chk("motor_on_before_reset", motor_en, 1);
    reset = 1'b0;
    @(posedge CLOCK_50);
    #1;
    chk("reset_motor_en", motor_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_dose_count", dose_count, 0);
    chk("reset_miss_alarm", miss_alarm, 0);
    chk("reset_miss_slot", miss_slot, 0);
    reset = 1'b1;
    exp_dose = 0;
    repeat (6) @(posedge CLOCK_50);
    #1;
    chk("pending_cleared_by_reset", busy, 0);
    for (int k = 0; k < 260; k++) single($urandom_range(0, 2), $urandom_range(1, 20), $urandom_range(4, 6), 1);
    chk("dose_saturated", dose_count, 255);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1_200_000;
    errors++;
    $display("FAIL watchdog: simulation exceeded its cycle budget at cyc %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
